// File: rtl/sga_direction_input_if.sv
// Handshake bundle between the Snake Game Arcade UC/datapath and the direction
// input conditioner: raw buttons in, validated direction and status out.
interface sga_direction_input_if;
  logic [3:0] buttons;
  logic       enable;
  logic       consume;
  logic [1:0] direction;
  logic       dir_pending;
  logic       press_pulse;
  logic [3:0] db_buttons;

  modport master (
    output buttons, enable, consume,
    input  direction, dir_pending, press_pulse, db_buttons
  );

  modport slave (
    input  buttons, enable, consume,
    output direction, dir_pending, press_pulse, db_buttons
  );
endinterface

// File: rtl/sga_direction_input.sv
// Synchronizes, debounces and edge-detects the four direction buttons, rejects
// reversals/no-ops/multi-presses and buffers one pending turn until a move step.
module sga_direction_input #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic             clock,
  input logic             reset,
  sga_direction_input_if.slave bus
);

  localparam logic [0:0]       EMPTY    = 1'b0;
  localparam logic [0:0]       PENDING  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1, sync2;
  logic [3:0]       db, db_d;
  logic [CNT_W-1:0] cnt [4];
  logic [0:0]       state;
  logic [1:0]       direction, next_dir;
  logic             press_pulse;

  logic [3:0] rise;
  logic       cand_valid;
  logic [1:0] cand;
  logic [1:0] ref_dir;
  logic       step;
  logic       accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.buttons;
      sync2 <= sync1;
    end
  end

  // The counter only advances while the synced level disagrees with the
  // accepted level; any return to agreement throws the partial count away.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      db_d <= db;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = db & ~db_d;

  // NOTE: every combinational output gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    cand_valid = 1'b0;
    cand       = 2'b00;
    case (rise)
      4'b0001: begin cand_valid = 1'b1; cand = 2'b00; end
      4'b0010: begin cand_valid = 1'b1; cand = 2'b01; end
      4'b0100: begin cand_valid = 1'b1; cand = 2'b10; end
      4'b1000: begin cand_valid = 1'b1; cand = 2'b11; end
      default: ;
    endcase
  end

  // A move step in this very cycle commits next_dir, so a simultaneous press is
  // judged against the direction the snake is about to take.
  assign step    = bus.consume && (state == PENDING);
  assign ref_dir = step ? next_dir : direction;
  assign accept  = cand_valid && bus.enable &&
                   (cand != (ref_dir ^ 2'b10)) && (cand != ref_dir);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      direction   <= 2'b00;
      next_dir    <= 2'b00;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= accept;
      if (step) direction <= next_dir;
      if (accept) begin
        next_dir <= cand;
        state    <= PENDING;
      end else if (step) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.direction   = direction;
  assign bus.dir_pending = (state == PENDING);
  assign bus.press_pulse = press_pulse;
  assign bus.db_buttons  = db;

endmodule

// File: tb/tb_sga_direction_input.sv
// Scenario and randomized bench for sga_direction_input, compared each cycle
// against a behavioural model of the button conditioning and turn buffer.
module tb_sga_direction_input;

  localparam int DB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sga_direction_input_if bus ();

  sga_direction_input #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: two-stage pipeline of raw samples, accepted levels and how
  // long each synced level has disagreed with them, plus the turn buffer.
  logic [3:0] m_pipe [2];
  logic [3:0] m_db, m_db_prev;
  int         m_run [4];
  int         m_dir, m_next;
  logic       m_pend, m_pulse;

  task automatic model_reset();
    m_pipe[0] = '0; m_pipe[1] = '0;
    m_db = '0; m_db_prev = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_dir = 0; m_next = 0; m_pend = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_clock(input logic [3:0] b, input logic en, input logic cons);
    logic [3:0] new_db;
    logic [3:0] rose;
    int         n_rose, cand, ref_d;
    bit         acc, commit;
    rose   = m_db & ~m_db_prev;
    new_db = m_db;
    for (int i = 0; i < 4; i++) begin
      if (m_pipe[1][i] != m_db[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= DB) begin
          new_db[i] = ~m_db[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    n_rose = 0;
    cand   = 0;
    for (int i = 0; i < 4; i++) if (rose[i]) begin n_rose++; cand = i; end
    commit = cons && m_pend;
    ref_d  = commit ? m_next : m_dir;
    acc    = en && (n_rose == 1) && (cand != (ref_d + 2) % 4) && (cand != ref_d);
    m_pulse = acc;
    if (commit) m_dir = m_next;
    if (acc) begin
      m_next = cand;
      m_pend = 1'b1;
    end else if (commit) begin
      m_pend = 1'b0;
    end
    m_db_prev = m_db;
    m_db      = new_db;
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = b;
  endtask

  task automatic cycle(input logic [3:0] b, input logic en, input logic cons);
    bus.buttons = b;
    bus.enable  = en;
    bus.consume = cons;
    @(posedge clock);
    model_clock(b, en, cons);
    #1;
    vectors += 4;
    if (bus.direction !== 2'(m_dir)) begin
      miscompares++;
      $display("FAIL model_direction @%0t: got %0d expected %0d", $time, bus.direction, m_dir);
    end
    if (bus.dir_pending !== m_pend) begin
      miscompares++;
      $display("FAIL model_dir_pending @%0t: got %0b expected %0b", $time, bus.dir_pending, m_pend);
    end
    if (bus.press_pulse !== m_pulse) begin
      miscompares++;
      $display("FAIL model_press_pulse @%0t: got %0b expected %0b", $time, bus.press_pulse, m_pulse);
    end
    if (bus.db_buttons !== m_db) begin
      miscompares++;
      $display("FAIL model_db_buttons @%0t: got %b expected %b", $time, bus.db_buttons, m_db);
    end
  endtask

  task automatic run(input logic [3:0] b, input logic en, input logic cons,
                     input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      cycle(b, en, cons);
      if (bus.press_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic do_reset();
    bus.buttons = '0; bus.enable = 1'b0; bus.consume = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic expect_state(input string name, input logic [1:0] dir, input logic pend);
    vectors += 2;
    if (bus.direction !== dir) begin
      miscompares++;
      $display("FAIL %s_direction: got %0d expected %0d", name, bus.direction, dir);
    end
    if (bus.dir_pending !== pend) begin
      miscompares++;
      $display("FAIL %s_dir_pending: got %0b expected %0b", name, bus.dir_pending, pend);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 2;
    if (bus.press_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_press_pulse: got %0b expected 0", bus.press_pulse);
    end
    if (bus.db_buttons !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_db_buttons: got %b expected 0000", bus.db_buttons);
    end
    expect_state("reset", 2'b00, 1'b0);
  endtask

  // A clean held press: level accepted after 2+DB cycles, pulse one cycle later, once.
  task automatic single_press_timing(input string name);
    int pulses;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle(4'b0010, 1'b1, 1'b0);
      vectors += 2;
      if (bus.db_buttons[1] !== (k >= 2 + DB)) begin
        miscompares++;
        $display("FAIL %s_db_timing cycle %0d: got %0b expected %0b", name, k, bus.db_buttons[1], k >= 2 + DB);
      end
      if (bus.press_pulse !== (k == 3 + DB)) begin
        miscompares++;
        $display("FAIL %s_pulse_timing cycle %0d: got %0b expected %0b", name, k, bus.press_pulse, k == 3 + DB);
      end
      if (bus.press_pulse === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL %s_pulse_count: got %0d expected 1", name, pulses);
    end
    expect_state(name, 2'b00, 1'b1);
    cycle(4'b0010, 1'b1, 1'b1);
    expect_state({name, "_consume"}, 2'b01, 1'b0);
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
  endtask

  task automatic test_single_press();
    do_reset();
    single_press_timing("press");
  endtask

  task automatic test_bounce();
    int pulses, total;
    do_reset();
    total = 0;
    for (int k = 0; k < 6; k++) begin
      run((k % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b0, 2, pulses);
      total += pulses;
      vectors++;
      if (bus.db_buttons !== 4'b0000) begin
        miscompares++;
        $display("FAIL bounce_db: got %b expected 0000", bus.db_buttons);
      end
    end
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
    total += pulses;
    vectors++;
    if (total != 0) begin
      miscompares++;
      $display("FAIL bounce_pulses: got %0d expected 0", total);
    end
    expect_state("bounce", 2'b00, 1'b0);
  endtask

  task automatic test_reversal();
    int pulses;
    do_reset();
    run(4'b0100, 1'b1, 1'b0, DB + 6, pulses);
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reversal_pulse: got %0d expected 0", pulses);
    end
    expect_state("reversal", 2'b00, 1'b0);
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
    run(4'b1000, 1'b1, 1'b0, DB + 6, pulses);
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL down_pulse: got %0d expected 1", pulses);
    end
    run(4'b0000, 1'b1, 1'b1, 1, pulses);
    expect_state("down_commit", 2'b11, 1'b0);
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
  endtask

  task automatic test_multi_press();
    int pulses;
    do_reset();
    run(4'b0011, 1'b1, 1'b0, DB + 6, pulses);
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL multi_pulse: got %0d expected 0", pulses);
    end
    expect_state("multi", 2'b00, 1'b0);
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
    run(4'b0010, 1'b0, 1'b0, DB + 6, pulses);
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL disabled_pulse: got %0d expected 0", pulses);
    end
    // Re-enabling while still held must not manufacture a press.
    run(4'b0010, 1'b1, 1'b0, 4, pulses);
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL held_reenable_pulse: got %0d expected 0", pulses);
    end
    expect_state("disabled", 2'b00, 1'b0);
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
  endtask

  task automatic test_back_to_back();
    int pulses, total;
    do_reset();
    run(4'b0010, 1'b1, 1'b0, DB + 6, pulses);
    total = pulses;
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
    run(4'b1000, 1'b1, 1'b0, DB + 6, pulses);
    total += pulses;
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
    vectors++;
    if (total != 2) begin
      miscompares++;
      $display("FAIL overwrite_pulses: got %0d expected 2", total);
    end
    expect_state("overwrite", 2'b00, 1'b1);
    // Left rises so the candidate forms in the same cycle consume commits down.
    run(4'b0100, 1'b1, 1'b0, 2 + DB, pulses);
    run(4'b0100, 1'b1, 1'b1, 1, pulses);
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL simultaneous_pulse: got %0d expected 1", pulses);
    end
    expect_state("simultaneous", 2'b11, 1'b1);
    run(4'b0000, 1'b1, 1'b1, 1, pulses);
    expect_state("left_commit", 2'b10, 1'b0);
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
  endtask

  task automatic test_async_reset();
    int pulses;
    do_reset();
    run(4'b0010, 1'b1, 1'b0, DB + 6, pulses);
    run(4'b0000, 1'b1, 1'b0, DB + 4, pulses);
    run(4'b1000, 1'b1, 1'b0, 2 + DB + 1, pulses);
    run(4'b0001, 1'b1, 1'b0, 3, pulses);
    expect_state("pre_async", 2'b00, 1'b1);
    #2;
    reset = 1'b1;
    bus.buttons = '0;
    #1;
    model_reset();
    vectors++;
    if (bus.db_buttons !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_db_buttons: got %b expected 0000", bus.db_buttons);
    end
    expect_state("async", 2'b00, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    single_press_timing("post_reset");
  endtask

  task automatic test_random();
    int         pulses, mode, hold;
    logic [3:0] b;
    logic       en;
    do_reset();
    for (int it = 0; it < 90; it++) begin
      mode = $urandom_range(0, 9);
      hold = $urandom_range(1, 10);
      en   = ($urandom_range(0, 9) != 0);
      if (mode < 7)       b = 4'(1 << $urandom_range(0, 3));
      else if (mode == 7) b = 4'($urandom_range(0, 15));
      else                b = 4'b0000;
      for (int k = 0; k < hold; k++) begin
        logic [3:0] drive;
        drive = (mode == 9 && k % 2 == 1) ? 4'(1 << $urandom_range(0, 3)) : b;
        run(drive, en, ($urandom_range(0, 4) == 0), 1, pulses);
      end
    end
  endtask

  initial begin
    bus.buttons = '0;
    bus.enable  = 1'b0;
    bus.consume = 1'b0;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_reversal();
    test_multi_press();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sga_direction_input.md
Name: sga_direction_input

Overview:
- Conditions the four raw direction buttons of the Snake Game Arcade and feeds the datapath with a single validated movement direction.
- Sits directly upstream of the datapath `buttons` consumer.
- Synchronizes and debounces each button, then detects presses.
- Rejects illegal moves: 180° reversals and multi-button presses.
- Buffers one pending turn, which is applied when the datapath takes a move step.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a button level change is accepted (1 ms at 50 MHz).
- CNT_W, 16: width of each debounce counter. It must hold DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- buttons  input  4  raw active-high buttons: [0] right, [1] up, [2] left, [3] down.
- enable  input  1  from the UC; high while the game is in a play state. Presses seen while low are discarded.
- consume  input  1  one-cycle pulse from the UC/datapath at each snake move step.
- direction  output  2  committed movement direction: 00 right, 01 up, 10 left, 11 down.
- dir_pending  output  1  high while a validated turn is buffered.
- press_pulse  output  1  one-cycle pulse when a press is accepted into the buffer.
- db_buttons  output  4  debounced button levels, for debug.

Behaviour:
- Reset values (asynchronous, all outputs): direction=00, dir_pending=0, press_pulse=0, db_buttons=0000. Synchronizers and counters clear to 0.
- Synchronizer: each button passes through a 2-FF synchronizer.
- Debounce, per bit:
  - A counter increments while the synced level differs from db_buttons[i], and clears while they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, db_buttons[i] toggles next cycle and the counter clears.
  - Any glitch back to the old level before that point clears the counter.
- Edge detect: rise[i] = db_buttons[i] & ~db_buttons_d[i].
- Latency: from a raw rising edge held stable to press_pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Candidate press: exactly one rise bit set, with enable=1. The cand index equals the encoding.
  - Zero rises, or two or more rises in the same cycle, produce no candidate.
- Reference direction ref:
  - ref = next_dir if consume=1 and dir_pending=1.
  - ref = direction otherwise.
- Candidate rejection: the candidate is rejected if cand == ref^2'b10 (reversal) or cand == ref (no-op).
- Buffer FSM, two states:
  - EMPTY (dir_pending=0):
    - An accepted candidate loads next_dir=cand, moves to PENDING, and pulses press_pulse.
    - consume has no effect.
  - PENDING (dir_pending=1):
    - consume alone: direction<=next_dir, go to EMPTY.
    - Accepted candidate without consume: next_dir is overwritten (last press wins), stay in PENDING, press_pulse=1. Validation is against direction.
    - consume and accepted candidate in the same cycle: direction<=old next_dir, next_dir<=cand, stay in PENDING, press_pulse=1. Validation is against the old next_dir.
- enable low:
  - The debounce and edge paths keep running, but no candidate is formed.
  - The buffer holds its state; consume is still honoured.
- Falling edges and held buttons generate nothing. Holding a button never repeats.
- Reset mid-debounce or with a pending turn returns to the reset state immediately. The counters restart.

Test Plan:
(Simulation uses DEBOUNCE_CYCLES=4.)
1. Reset, then enable=1, then hold buttons=0010 (up) for 10 cycles. Required: db_buttons[1]=1 exactly 6 cycles after the edge, press_pulse one cycle later, dir_pending=1. Then pulse consume: direction=01, dir_pending=0.
2. Bounce: toggle buttons[1] every 2 cycles for 12 cycles, then release. Required: db_buttons stays 0000, no press_pulse, direction=00.
3. Reversal: with direction=00 (right), press left (0100). Required: no press_pulse, dir_pending=0. Then press down (1000) and consume: direction=11.
4. Multi-press: raise buttons=0011 in the same cycle. Required: no press_pulse, dir_pending=0. Also, a press with enable=0 produces no press_pulse.
5. Overwrite and simultaneous events:
   - From direction=00, press up; then press down before consume. Required: next_dir=11, dir_pending=1, two press_pulses.
   - Next, press left landing in the same cycle as consume. Required: direction=11, next_dir=10, dir_pending=1.
6. Assert reset asynchronously while dir_pending=1 and mid-debounce. Required: direction=00, dir_pending=0, db_buttons=0000 without waiting for a clock edge. A fresh press afterwards behaves as in scenario 1.
